// File: rtl/axis_fir_sym_pkg.sv
// rtl/axis_fir_sym_pkg.sv - shared FSM type, width helpers and output formatting for axis_fir_sym_mc
package axis_fir_sym_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DRAIN, ST_OUT} state_t;

  // Flush covers the three arithmetic stages plus the output formatting register.
  localparam int FLUSH_CYCLES = 4;

  function automatic int acc_width(input int dw, input int cw, input int h);
    return dw + cw + 1 + $clog2(h);
  endfunction

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic signed [63:0] fmt_out(input logic signed [63:0] v, input int dw,
                                                 input bit sat);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (sat && (v > hi)) return hi;
    if (sat && (v < lo)) return lo;
    return v;
  endfunction

endpackage

// File: rtl/axis_fir_sym_delay_line.sv
// rtl/axis_fir_sym_delay_line.sv - one channel's sample history with two mirrored read ports
module axis_fir_sym_delay_line
  import axis_fir_sym_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int N_TAPS     = 64,
  parameter int IDX_W      = $clog2(N_TAPS)
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] din,
  input  logic        [IDX_W-1:0]      idx_a,
  input  logic        [IDX_W-1:0]      idx_b,
  output logic signed [DATA_WIDTH-1:0] tap_a,
  output logic signed [DATA_WIDTH-1:0] tap_b
);

  logic signed [DATA_WIDTH-1:0] taps [N_TAPS];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < N_TAPS; i++) taps[i] <= '0;
    end else if (en) begin
      taps[0] <= din;
      for (int i = 1; i < N_TAPS; i++) taps[i] <= taps[i-1];
    end
  end

  assign tap_a = taps[idx_a];
  assign tap_b = taps[idx_b];

endmodule

// File: rtl/axis_fir_sym_mc.sv
// rtl/axis_fir_sym_mc.sv - multichannel sequential symmetric FIR on AXI-Stream, one pre-add/MAC
// AXIS_FIR_SYM_SATURATE_EN: clamp the shifted accumulator to the output range instead of wrapping.
module axis_fir_sym_mc
  import axis_fir_sym_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int N_TAPS      = 64,
  parameter int N_CHANNELS  = 1,
  parameter int OUT_SHIFT   = 15,
  localparam int H    = N_TAPS / 2,
  localparam int AW   = $clog2(H),
  localparam int CH_W = ch_width(N_CHANNELS)
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic        [AW-1:0]          coeff_addr,
  input  logic signed [COEFF_WIDTH-1:0] coeff_data,
  input  logic                          coeff_valid,
  output logic                          coeff_ready,
  input  logic signed [DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic        [CH_W-1:0]        s_axis_tid,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic signed [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic        [CH_W-1:0]        m_axis_tid,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready
);

  localparam int TW     = $clog2(N_TAPS);
  localparam int PW     = DATA_WIDTH + COEFF_WIDTH + 1;
  localparam int ACW    = acc_width(DATA_WIDTH, COEFF_WIDTH, H);
  localparam int NCH_P2 = 1 << CH_W;
`ifdef AXIS_FIR_SYM_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  state_t                        state;
  logic        [AW-1:0]          cnt;
  logic        [2:0]             dcnt;
  logic        [CH_W-1:0]        cur_tid;
  logic signed [COEFF_WIDTH-1:0] coef [H];
  logic signed [DATA_WIDTH-1:0]  tap_a [NCH_P2];
  logic signed [DATA_WIDTH-1:0]  tap_b [NCH_P2];
  logic        [TW-1:0]          idx_a;
  logic        [TW-1:0]          idx_b;
  logic                          s_hs;
  logic                          tid_ok;
  logic signed [DATA_WIDTH:0]    pre;
  logic signed [COEFF_WIDTH-1:0] pre_c;
  logic signed [PW-1:0]          prod;
  logic signed [ACW-1:0]         acc;
  logic signed [ACW-1:0]         shifted;
  logic                          v1, v2, f1, f2;

  assign s_hs    = s_axis_tvalid && s_axis_tready;
  assign tid_ok  = int'(s_axis_tid) < N_CHANNELS;
  assign idx_a   = TW'(cnt);
  assign idx_b   = TW'(N_TAPS - 1) - idx_a;
  assign shifted = acc >>> OUT_SHIFT;

  // Unused slots of the power-of-two mux read as zero; cur_tid never selects them.
  for (genvar ch = 0; ch < NCH_P2; ch++) begin : g_ch
    if (ch < N_CHANNELS) begin : g_line
      axis_fir_sym_delay_line #(
        .DATA_WIDTH(DATA_WIDTH), .N_TAPS(N_TAPS), .IDX_W(TW)
      ) u_line (
        .clk   (clk),
        .resetn(resetn),
        .en    (s_hs && tid_ok && (s_axis_tid == CH_W'(ch))),
        .din   (s_axis_tdata),
        .idx_a (idx_a),
        .idx_b (idx_b),
        .tap_a (tap_a[ch]),
        .tap_b (tap_b[ch])
      );
    end else begin : g_unused
      assign tap_a[ch] = '0;
      assign tap_b[ch] = '0;
    end
  end

  // Coefficients survive reset; coeff_ready is low during reset so no write slips in.
  always_ff @(posedge clk) begin
    if (coeff_valid && coeff_ready) coef[coeff_addr] <= coeff_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      f1    <= 1'b0;
      f2    <= 1'b0;
      pre   <= '0;
      pre_c <= '0;
      prod  <= '0;
      acc   <= '0;
    end else begin
      v1    <= (state == ST_CALC);
      f1    <= (state == ST_CALC) && (cnt == '0);
      pre   <= {tap_a[cur_tid][DATA_WIDTH-1], tap_a[cur_tid]}
             + {tap_b[cur_tid][DATA_WIDTH-1], tap_b[cur_tid]};
      pre_c <= coef[cnt];
      v2    <= v1;
      f2    <= f1;
      prod  <= pre * pre_c;
      if (v2) acc <= f2 ? ACW'(prod) : acc + ACW'(prod);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      dcnt          <= '0;
      cur_tid       <= '0;
      s_axis_tready <= 1'b0;
      coeff_ready   <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tid    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          s_axis_tready <= 1'b1;
          coeff_ready   <= 1'b1;
          // Samples on an out-of-range TID are swallowed without leaving IDLE.
          if (s_hs && tid_ok) begin
            state         <= ST_CALC;
            cur_tid       <= s_axis_tid;
            cnt           <= '0;
            s_axis_tready <= 1'b0;
            coeff_ready   <= 1'b0;
          end
        end
        ST_CALC: begin
          cnt <= cnt + 1'b1;
          if (cnt == AW'(H - 1)) begin
            state <= ST_DRAIN;
            cnt   <= '0;
            dcnt  <= '0;
          end
        end
        ST_DRAIN: begin
          dcnt <= dcnt + 1'b1;
          if (dcnt == 3'(FLUSH_CYCLES - 1)) begin
            state         <= ST_OUT;
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= DATA_WIDTH'(fmt_out(64'(shifted), DATA_WIDTH, SAT));
            m_axis_tid    <= cur_tid;
          end
        end
        ST_OUT: begin
          if (m_axis_tready) begin
            state         <= ST_IDLE;
            m_axis_tvalid <= 1'b0;
            s_axis_tready <= 1'b1;
            coeff_ready   <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
